spn_round_engine: RTL

Iterative, parametrised SPN block cipher core: one substitution-permutation round per clock, generalising the fixed 16-bit/3-round toy cipher to configurable block width and round count, with an optional decrypt mode. It sits between the host-side request interface and the result buffer, using a valid/ready handshake on both sides. One block is processed at a time.

---
 rtl/spn_round_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spn_round_engine.sv
// rtl/spn_round_engine.sv - iterative SPN block cipher core, one round per clock
// Optional decrypt datapath is built when SPN_DECRYPT_EN is defined.
module spn_round_engine #(
    parameter int DATA_W = 16,
    parameter int ROUNDS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    input  logic              in_decrypt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    localparam int NIB     = DATA_W / 4;
    localparam int CW      = $clog2(ROUNDS + 1);
    localparam int SH_LAST = (4 * ROUNDS) % DATA_W;
    localparam int SH_PEN  = (4 * (ROUNDS - 1)) % DATA_W;
    localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Nibble i of the table is S(i).
    localparam logic [63:0] SBOX_TBL = 64'hA59B_178F_60DC_243E;

    logic [1:0]        state;
    logic [CW-1:0]     rnd;
    logic [DATA_W-1:0] blk;
    logic [DATA_W-1:0] rk;
    logic [DATA_W-1:0] kf;
    logic [DATA_W-1:0] enc_next;
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] rk_load;
    logic [DATA_W-1:0] rk_step;
    logic              last;

    function automatic logic [DATA_W-1:0] rotl_c(input logic [DATA_W-1:0] k, input int sh);
        logic [2*DATA_W-1:0] d;
        d = {k, k} << sh;
        return d[2*DATA_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rotl4(input logic [DATA_W-1:0] k);
        return {k[DATA_W-5:0], k[DATA_W-1:DATA_W-4]};
    endfunction

    function automatic logic [DATA_W-1:0] sub_layer(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] o;
        o = '0;
        for (int n = 0; n < NIB; n++)
            o[4*n +: 4] = SBOX_TBL[{s[4*n +: 4], 2'b00} +: 4];
        return o;
    endfunction

    function automatic logic [DATA_W-1:0] perm(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] o;
        o = '0;
        for (int n = 0; n < NIB; n++)
            for (int j = 0; j < 4; j++)
                o[j*NIB + n] = s[4*n + j];
        return o;
    endfunction

    assign last      = (rnd == LAST_RND);
    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign out_data  = blk;

    always_comb begin
        enc_next = sub_layer(blk ^ rk);
        if (last)
            enc_next = enc_next ^ kf;
        else
            enc_next = perm(enc_next);
    end

`ifdef SPN_DECRYPT_EN
    localparam logic [63:0] SINV_TBL = 64'h8054_CFD9_A7E2_13B6;

    logic              mode;
    logic [DATA_W-1:0] dec_pre;
    logic [DATA_W-1:0] dec_next;

    function automatic logic [DATA_W-1:0] rotr4(input logic [DATA_W-1:0] k);
        return {k[3:0], k[DATA_W-1:4]};
    endfunction

    function automatic logic [DATA_W-1:0] inv_sub_layer(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] o;
        o = '0;
        for (int n = 0; n < NIB; n++)
            o[4*n +: 4] = SINV_TBL[{s[4*n +: 4], 2'b00} +: 4];
        return o;
    endfunction

    function automatic logic [DATA_W-1:0] perm_inv(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] o;
        o = '0;
        for (int n = 0; n < NIB; n++)
            for (int j = 0; j < 4; j++)
                o[4*n + j] = s[j*NIB + n];
        return o;
    endfunction

    // Decrypt walks the round keys backwards starting from K_(ROUNDS-1).
    always_comb begin
        dec_pre  = (rnd == '0) ? (blk ^ kf) : perm_inv(blk);
        dec_next = inv_sub_layer(dec_pre) ^ rk;
        nxt      = mode ? dec_next : enc_next;
        rk_step  = mode ? rotr4(rk) : rotl4(rk);
        rk_load  = in_decrypt ? rotl_c(in_key, SH_PEN) : in_key;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mode <= 1'b0;
        else if (state == S_IDLE && in_valid)
            mode <= in_decrypt;
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = in_decrypt;

    always_comb begin
        nxt     = enc_next;
        rk_step = rotl4(rk);
        rk_load = in_key;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rnd   <= '0;
            blk   <= '0;
            rk    <= '0;
            kf    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        blk   <= in_data;
                        rk    <= rk_load;
                        kf    <= rotl_c(in_key, SH_LAST);
                        rnd   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    blk <= nxt;
                    rk  <= rk_step;
                    rnd <= rnd + 1'b1;
                    if (last)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
